// File: rtl/irq_seq_pkg.sv
// Shared state encoding, default addresses and PC helper for the IRQ/PC sequencer.
package irq_seq_pkg;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_ENTRY   = 2'd1,
        ST_HANDLER = 2'd2
    } seq_state_e;

    localparam logic [31:0] PC_RESET_DEF   = 32'h0000_3000;
    localparam logic [31:0] LOOP_HI_DEF    = 32'h0000_30A0;
    localparam logic [31:0] LOOP_LO_DEF    = 32'h0000_3000;
    localparam logic [31:0] HANDLER_PC_DEF = 32'h0000_4180;
    localparam logic [31:0] ACK_ADDR_DEF   = 32'h0000_7F20;

    localparam int ENTRY_CNT_W   = 4;
    localparam int HANDLER_CNT_W = 8;

    // Main-loop PC advance: wrap from the last loop PC back to the loop start.
    function automatic logic [31:0] loop_next_pc(input logic [31:0] pc,
                                                 input logic [31:0] hi,
                                                 input logic [31:0] lo);
        return (pc == hi) ? lo : pc + 32'd4;
    endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-index-wins priority encoder for interrupt acceptance.
module irq_prio_enc #(
    parameter int N = 4
) (
    input  logic [N-1:0] req,
    output logic         valid,
    output logic [2:0]   idx
);

    // Scan from the top so the lowest set index is the last one written.
    always_comb begin
        valid = |req;
        idx   = 3'd0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = 3'(i);
            end
        end
    end

endmodule

// File: rtl/irq_pc_sequencer.sv
// Macroscopic PC sequencer: runs a main loop, diverts to a fixed handler on
// interrupt acceptance, writes a one-cycle acknowledge, then returns.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_RUN     | main loop; pending/live requests are accepted here
// ST_ENTRY   | loop keeps advancing while the entry delay counts down
// ST_HANDLER | handler body executes, then PC returns to saved_pc
module irq_pc_sequencer
    import irq_seq_pkg::*;
#(
    parameter int          NUM_IRQ     = 4,
    parameter logic [31:0] PC_RESET    = PC_RESET_DEF,
    parameter logic [31:0] LOOP_HI     = LOOP_HI_DEF,
    parameter logic [31:0] LOOP_LO     = LOOP_LO_DEF,
    parameter logic [31:0] HANDLER_PC  = HANDLER_PC_DEF,
    parameter logic [31:0] ACK_ADDR    = ACK_ADDR_DEF,
    parameter int          ENTRY_DELAY = 2,
    parameter int          HANDLER_LEN = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_IRQ-1:0] irq,
    output logic [31:0]        macroscopic_pc,
    output logic [31:0]        m_data_addr,
    output logic [31:0]        m_data_wdata,
    output logic [3:0]         m_data_byteen,
    output logic               irq_busy,
    output logic [2:0]         irq_id
);

    localparam logic [ENTRY_CNT_W-1:0]   ENTRY_INIT   = ENTRY_CNT_W'(ENTRY_DELAY - 1);
    localparam logic [HANDLER_CNT_W-1:0] HANDLER_INIT = HANDLER_CNT_W'(HANDLER_LEN - 1);

    seq_state_e               state_q, state_d;
    logic [31:0]              pc_q, pc_d;
    logic [31:0]              saved_pc_q, saved_pc_d;
    logic [NUM_IRQ-1:0]       pending_q, pending_d;
    logic [ENTRY_CNT_W-1:0]   entry_cnt_q, entry_cnt_d;
    logic [HANDLER_CNT_W-1:0] handler_cnt_q, handler_cnt_d;
    logic [2:0]               irq_id_q, irq_id_d;
    logic [31:0]              ack_addr_q, ack_addr_d;
    logic [31:0]              ack_wdata_q, ack_wdata_d;
    logic [3:0]               ack_byteen_q, ack_byteen_d;

    logic [NUM_IRQ-1:0]       acc_req;
    logic [NUM_IRQ-1:0]       acc_mask;
    logic                     acc_valid;
    logic [2:0]               acc_idx;

    // A request raised on the accepting edge itself is eligible immediately.
    assign acc_req = pending_q | irq;

    irq_prio_enc #(
        .N (NUM_IRQ)
    ) u_prio_enc (
        .req   (acc_req),
        .valid (acc_valid),
        .idx   (acc_idx)
    );

    // One-hot of the winning channel, used to clear its pending bit.
    always_comb begin
        acc_mask = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (3'(i) == acc_idx) begin
                acc_mask[i] = acc_valid;
            end
        end
    end

    // Next-state, PC sequencing, pending bookkeeping and acknowledge strobe.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        saved_pc_d    = saved_pc_q;
        pending_d     = pending_q | irq;
        entry_cnt_d   = entry_cnt_q;
        handler_cnt_d = handler_cnt_q;
        irq_id_d      = irq_id_q;
        ack_addr_d    = '0;
        ack_wdata_d   = '0;
        ack_byteen_d  = '0;

        case (state_q)
            ST_RUN: begin
                pc_d = loop_next_pc(pc_q, LOOP_HI, LOOP_LO);
                if (acc_valid) begin
                    saved_pc_d   = pc_q;
                    irq_id_d     = acc_idx;
                    pending_d    = (pending_q | irq) & ~acc_mask;
                    entry_cnt_d  = ENTRY_INIT;
                    state_d      = ST_ENTRY;
                    ack_addr_d   = ACK_ADDR;
                    ack_wdata_d  = {29'b0, acc_idx};
                    ack_byteen_d = 4'b0001;
                end
            end
            ST_ENTRY: begin
                if (entry_cnt_q == '0) begin
                    pc_d          = HANDLER_PC;
                    handler_cnt_d = HANDLER_INIT;
                    state_d       = ST_HANDLER;
                end else begin
                    pc_d        = loop_next_pc(pc_q, LOOP_HI, LOOP_LO);
                    entry_cnt_d = entry_cnt_q - 1'b1;
                end
            end
            ST_HANDLER: begin
                if (handler_cnt_q == '0) begin
                    pc_d    = saved_pc_q;
                    state_d = ST_RUN;
                end else begin
                    pc_d          = pc_q + 32'd4;
                    handler_cnt_d = handler_cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // State register with synchronous active-low reset overriding any sequence.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= ST_RUN;
            pc_q          <= PC_RESET;
            saved_pc_q    <= '0;
            pending_q     <= '0;
            entry_cnt_q   <= '0;
            handler_cnt_q <= '0;
            irq_id_q      <= '0;
            ack_addr_q    <= '0;
            ack_wdata_q   <= '0;
            ack_byteen_q  <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            saved_pc_q    <= saved_pc_d;
            pending_q     <= pending_d;
            entry_cnt_q   <= entry_cnt_d;
            handler_cnt_q <= handler_cnt_d;
            irq_id_q      <= irq_id_d;
            ack_addr_q    <= ack_addr_d;
            ack_wdata_q   <= ack_wdata_d;
            ack_byteen_q  <= ack_byteen_d;
        end
    end

    assign macroscopic_pc = pc_q;
    assign m_data_addr    = ack_addr_q;
    assign m_data_wdata   = ack_wdata_q;
    assign m_data_byteen  = ack_byteen_q;
    assign irq_busy       = (state_q != ST_RUN);
    assign irq_id         = irq_id_q;

endmodule
